uart_loopback_bist: RTL

UART_LOOPBACK_BIST -- requirements
Module: uart_loopback_bist

---
 rtl/uart_loopback_bist.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_loopback_bist.sv
// Loopback self-test for uart_top: configures baud and enables, streams an LFSR byte
// pattern into TX in bursts no deeper than the TX FIFO, and checks each byte popped from RX.
`ifndef UART_UART_CFG_ADDR
`define UART_UART_CFG_ADDR    5'h00
`endif
`ifndef UART_UART_STATUS_ADDR
`define UART_UART_STATUS_ADDR 5'h04
`endif
`ifndef UART_TX_DATA_ADDR
`define UART_TX_DATA_ADDR     5'h08
`endif
`ifndef UART_RX_DATA_ADDR
`define UART_RX_DATA_ADDR     5'h0C
`endif
`ifndef UART_BAUD_CFG_ADDR
`define UART_BAUD_CFG_ADDR    5'h10
`endif

module uart_loopback_bist #(
    parameter int unsigned NUM_BYTES = 24,
    parameter int unsigned BURST     = 4,
    parameter int unsigned BAUD_DIV  = 8,
    parameter logic [7:0]  SEED      = 8'hA5,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic [4:0]  reg_raddr_o,
    input  logic [31:0] reg_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [7:0]  err_cnt_o,
    output logic [8:0]  byte_cnt_o,
    output logic [7:0]  first_exp_o,
    output logic [7:0]  first_got_o
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
    localparam logic [8:0]    NB        = 9'(NUM_BYTES);
    localparam logic [8:0]    BL        = 9'(BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_BAUD,
        S_CFG_EN,
        S_WR,
        S_POLL,
        S_RD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      tx_lfsr_q, tx_lfsr_d;
    logic [7:0]      rx_lfsr_q, rx_lfsr_d;
    logic [8:0]      wr_cnt_q, wr_cnt_d;
    logic [8:0]      rd_cnt_q, rd_cnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [7:0]      first_exp_q, first_exp_d;
    logic [7:0]      first_got_q, first_got_d;
    logic            timeout_q, timeout_d;
    logic [8:0]      wr_nxt;
    logic [8:0]      rd_nxt;
    logic [TW-1:0]   tmo_nxt;
    logic            rdata_unused;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    assign rdata_unused = ^reg_rdata_i[31:8];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            tx_lfsr_q   <= 8'h00;
            rx_lfsr_q   <= 8'h00;
            wr_cnt_q    <= 9'd0;
            rd_cnt_q    <= 9'd0;
            tmo_cnt_q   <= '0;
            err_cnt_q   <= 8'd0;
            first_exp_q <= 8'd0;
            first_got_q <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_lfsr_q   <= tx_lfsr_d;
            rx_lfsr_q   <= rx_lfsr_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_lfsr_d   = tx_lfsr_q;
        rx_lfsr_d   = rx_lfsr_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;
        timeout_d   = timeout_q;
        reg_we_o    = 1'b0;
        reg_waddr_o = 5'd0;
        reg_wdata_o = 32'd0;
        reg_raddr_o = `UART_UART_STATUS_ADDR;
        wr_nxt      = wr_cnt_q + 9'd1;
        rd_nxt      = rd_cnt_q + 9'd1;
        tmo_nxt     = tmo_cnt_q + 1'b1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d     = S_CFG_BAUD;
                    tx_lfsr_d   = SEED;
                    rx_lfsr_d   = SEED;
                    wr_cnt_d    = 9'd0;
                    rd_cnt_d    = 9'd0;
                    tmo_cnt_d   = '0;
                    err_cnt_d   = 8'd0;
                    first_exp_d = 8'd0;
                    first_got_d = 8'd0;
                    timeout_d   = 1'b0;
                end
            end
            S_CFG_BAUD: begin
                reg_we_o    = 1'b1;
                reg_waddr_o = `UART_BAUD_CFG_ADDR;
                reg_wdata_o = 32'(BAUD_DIV);
                state_d     = S_CFG_EN;
            end
            S_CFG_EN: begin
                reg_we_o    = 1'b1;
                reg_waddr_o = `UART_UART_CFG_ADDR;
                reg_wdata_o = 32'h5;
                state_d     = S_WR;
            end
            S_WR: begin
                reg_we_o    = 1'b1;
                reg_waddr_o = `UART_TX_DATA_ADDR;
                reg_wdata_o = {24'h0, tx_lfsr_q};
                tx_lfsr_d   = lfsr_step(tx_lfsr_q);
                wr_cnt_d    = wr_nxt;
                // WR is only entered with nothing outstanding, so wr-rd is the burst length so far
                if ((wr_nxt - rd_cnt_q) == BL || wr_nxt == NB) begin
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                tmo_cnt_d = tmo_nxt;
                if (reg_rdata_i[0]) begin
                    state_d = S_RD;
                end else if (tmo_nxt == TMO_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_RD: begin
                reg_raddr_o = `UART_RX_DATA_ADDR;
                rx_lfsr_d   = lfsr_step(rx_lfsr_q);
                rd_cnt_d    = rd_nxt;
                tmo_cnt_d   = '0;
                if (reg_rdata_i[7:0] != rx_lfsr_q) begin
                    // err_cnt saturates, so zero reliably marks "no mismatch captured yet"
                    if (err_cnt_q == 8'd0) begin
                        first_exp_d = rx_lfsr_q;
                        first_got_d = reg_rdata_i[7:0];
                    end
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                if (rd_nxt == NB) begin
                    state_d = S_DONE;
                end else if (rd_nxt == wr_cnt_q) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_POLL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o      = (state_q == S_CFG_BAUD) || (state_q == S_CFG_EN) || (state_q == S_WR) ||
                         (state_q == S_POLL) || (state_q == S_RD);
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = (state_q == S_DONE) && (err_cnt_q == 8'd0) && !timeout_q;
    assign timeout_o   = timeout_q;
    assign err_cnt_o   = err_cnt_q;
    assign byte_cnt_o  = rd_cnt_q;
    assign first_exp_o = first_exp_q;
    assign first_got_o = first_got_q;

endmodule
